dmem_bridge: RTL and testbench
==============================

// Module: dmem_bridge
// PURPOSE
// Sits directly downstream of the pipeline's MEM stage, between its proc2Dmem_* outputs and a multi-cycle
// data memory using a req/gnt/rvalid handshake. Converts each BUS_LOAD/BUS_STORE into one memory transaction.
// Generates byte strobes and aligned load data (sign/zero-extended per funct3), and stalls the pipeline
// until the transaction completes, faults or times out.
// PARAMETERS
// TIMEOUT_CYCLES  64  cycles waited in REQ or WAIT before aborting with bus_err (>=2)
// ERR_DATA        0   32-bit value returned on mem2proc_data for a faulted/timed-out load
// PORTS
// clk                input   1   system clock, rising edge
// rst_n              input   1   asynchronous, active-low reset
// proc2Dmem_command  input   2   BUS_NONE=0, BUS_LOAD=1, BUS_STORE=2; held stable by pipeline while stall=1
// proc2Dmem_addr     input   32  byte address
// proc2mem_data      input   32  store data, LSB-justified
// mem_funct3         input   3   [1:0] 00=byte 01=half 10=word 11=illegal; [2]=unsigned load
// mem2proc_data      output  32  aligned, extended load result; valid in DONE cycle only
// dmem_stall         output  1   freeze IF..MEM stages and pipeline registers
// bus_err            output  1   one-cycle pulse in DONE for misalign/illegal size/timeout
// mem_req            output  1   request to data memory (registered)
// mem_we             output  1   1=write (registered, valid with mem_req)
// mem_addr           output  32  word address {addr[31:2],2'b00} (registered)
// mem_wdata          output  32  replicated store data (registered)
// mem_wstrb          output  4   byte enables; 4'b0000 on reads (registered)
// mem_gnt            input   1   memory accepts request this cycle
// mem_rvalid         input   1   read data valid this cycle
// mem_rdata          input   32  read data word
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0,
//   mem2proc_data=0, bus_err=0, timeout counter=0. Reset mid-transaction drops mem_req immediately; no retry.
// - dmem_stall = (command!=BUS_NONE) && (state!=DONE); combinational. Zero in IDLE with BUS_NONE.
// - FSM states IDLE, REQ, WAIT, DONE:
//   IDLE: command!=NONE and aligned -> REQ, register mem_req=1, mem_we=(STORE), addr/wdata/wstrb.
//         command!=NONE and misaligned (half addr[0]=1, word addr[1:0]!=0) or funct3[1:0]=11 -> DONE
//         with error; no memory access.
//   REQ:  hold mem_* stable. mem_gnt=1 -> drop mem_req; STORE -> DONE, LOAD -> WAIT. Counter reset on exit.
//   WAIT: mem_rvalid=1 -> capture+extend mem_rdata into mem2proc_data, -> DONE. rvalid in REQ is ignored.
//   DONE: stall low one cycle (pipeline advances); bus_err pulses if faulted; -> IDLE unconditionally.
// - Timeout: counter increments each cycle in REQ/WAIT; reaching TIMEOUT_CYCLES -> drop mem_req, DONE with
//   bus_err, mem2proc_data=ERR_DATA. Late gnt/rvalid arriving in IDLE/DONE are ignored.
// - Min latency: store 2 stall cycles (IDLE,REQ with gnt), load 3 (IDLE,REQ,WAIT with rvalid same cycles).
// - Store data: byte {4{d[7:0]}}, wstrb=1<<addr[1:0]; half {2{d[15:0]}}, wstrb=addr[1]?1100:0011; word d, 1111.
// - Load extract: byte = rdata>>(8*addr[1:0]), half = rdata>>(16*addr[1]); sign-extend unless funct3[2].
// - Back-to-back ops: new command seen in IDLE the cycle after DONE starts a fresh transaction.
// - mem2proc_data holds its last value outside DONE; bus_err is 0 outside DONE.
// TESTING
// 1. LOAD word addr=0x100, gnt cycle1, rvalid cycle2 rdata=0xCAFEF00D -> mem_addr=0x100, stall 3 cycles,
//    mem2proc_data=0xCAFEF00D in DONE, bus_err=0.
// 2. STORE byte addr=0x103 data=0x000000A5 -> mem_wdata=0xA5A5A5A5, mem_wstrb=4'b1000, mem_we=1, stall 2 cycles.
// 3. LOAD byte signed addr=0x102 rdata=0x0080FF00 -> 0xFFFFFF80; same with funct3[2]=1 -> 0x00000080.
// 4. LOAD half addr=0x101 -> no mem_req ever, DONE next cycle, bus_err=1 pulse, stall 1 cycle.
// 5. LOAD with mem_gnt never asserted, TIMEOUT_CYCLES=8 -> mem_req drops after 8 REQ cycles,
//    mem2proc_data=ERR_DATA, bus_err=1 for one cycle, then IDLE.
// 6. rst_n low during WAIT -> mem_req=0 and all outputs zero same instant; rvalid after release ignored.

Source files
------------

// File: rtl/dmem_bridge.sv
// dmem_bridge: turns MEM-stage load/store commands into req/gnt/rvalid memory transactions and stalls the pipeline until done
module dmem_bridge #(
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [31:0] ERR_DATA       = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  proc2Dmem_command,
    input  logic [31:0] proc2Dmem_addr,
    input  logic [31:0] proc2mem_data,
    input  logic [2:0]  mem_funct3,
    output logic [31:0] mem2proc_data,
    output logic        dmem_stall,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CMAX = CW'(TIMEOUT_CYCLES - 1);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    state_t state;
    logic [CW-1:0] cnt;
    logic [1:0] size;
    logic is_ld, is_st, bad, tmo, sx;
    logic [7:0] byte_v;
    logic [15:0] half_v;
    logic [31:0] wdata_n, ld_v;
    logic [3:0] wstrb_n;
    assign size = mem_funct3[1:0];
    assign is_ld = proc2Dmem_command == 2'd1;
    assign is_st = proc2Dmem_command == 2'd2;
    assign bad = (size == 2'b11) || (size == 2'b01 && proc2Dmem_addr[0])
              || (size == 2'b10 && proc2Dmem_addr[1:0] != 2'b00) || (proc2Dmem_command == 2'd3);
    assign tmo = cnt == CMAX;
    assign dmem_stall = (proc2Dmem_command != 2'd0) && (state != DONE);
    assign wdata_n = size == 2'b00 ? {4{proc2mem_data[7:0]}}
                   : size == 2'b01 ? {2{proc2mem_data[15:0]}} : proc2mem_data;
    assign wstrb_n = !is_st ? 4'b0000
                   : size == 2'b00 ? 4'b0001 << proc2Dmem_addr[1:0]
                   : size == 2'b01 ? (proc2Dmem_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign byte_v = 8'(mem_rdata >> {proc2Dmem_addr[1:0], 3'b000});
    assign half_v = 16'(mem_rdata >> {proc2Dmem_addr[1], 4'b0000});
    assign sx = !mem_funct3[2];
    assign ld_v = size == 2'b00 ? {{24{sx & byte_v[7]}}, byte_v}
                : size == 2'b01 ? {{16{sx & half_v[15]}}, half_v} : mem_rdata;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            mem_req <= 1'b0;
            mem_we <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            mem2proc_data <= '0;
            bus_err <= 1'b0;
        end else begin
            case (state)
                IDLE: if (proc2Dmem_command != 2'd0) begin
                    if (bad) begin
                        state <= DONE;
                        bus_err <= 1'b1;
                        if (is_ld) mem2proc_data <= ERR_DATA;
                    end else begin
                        state <= REQ;
                        mem_req <= 1'b1;
                        mem_we <= is_st;
                        mem_addr <= {proc2Dmem_addr[31:2], 2'b00};
                        mem_wdata <= wdata_n;
                        mem_wstrb <= wstrb_n;
                    end
                end
                REQ: if (mem_gnt) begin
                    mem_req <= 1'b0;
                    cnt <= '0;
                    state <= mem_we ? DONE : WAIT;
                end else if (tmo) begin
                    mem_req <= 1'b0;
                    cnt <= '0;
                    bus_err <= 1'b1;
                    state <= DONE;
                    if (!mem_we) mem2proc_data <= ERR_DATA;
                end else cnt <= cnt + 1'b1;
                WAIT: if (mem_rvalid) begin
                    mem2proc_data <= ld_v;
                    cnt <= '0;
                    state <= DONE;
                end else if (tmo) begin
                    cnt <= '0;
                    bus_err <= 1'b1;
                    mem2proc_data <= ERR_DATA;
                    state <= DONE;
                end else cnt <= cnt + 1'b1;
                DONE: begin
                    bus_err <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: randomized load/store traffic against a cycle-count and data reference model
module tb_dmem_bridge;
    localparam int TMO = 8;
    localparam logic [31:0] ERR = 32'hDEADBEEF;
    localparam logic [1:0] LD = 2'd1, ST = 2'd2;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [1:0] proc2Dmem_command = '0;
    logic [31:0] proc2Dmem_addr = '0, proc2mem_data = '0, mem_rdata = '0;
    logic [2:0] mem_funct3 = '0;
    logic mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem2proc_data, mem_addr, mem_wdata;
    logic dmem_stall, bus_err, mem_req, mem_we;
    logic [3:0] mem_wstrb;
    int n_cmp = 0, n_err = 0;
    logic [31:0] last = '0;

    dmem_bridge #(.TIMEOUT_CYCLES(TMO), .ERR_DATA(ERR)) dut (
        .clk(clk), .rst_n(rst_n), .proc2Dmem_command(proc2Dmem_command),
        .proc2Dmem_addr(proc2Dmem_addr), .proc2mem_data(proc2mem_data), .mem_funct3(mem_funct3),
        .mem2proc_data(mem2proc_data), .dmem_stall(dmem_stall), .bus_err(bus_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ext(input logic [31:0] w, input logic [31:0] a, input logic [2:0] f);
        int unsigned v;
        if (f[1:0] == 2'b00) begin
            v = (w >> (8 * (a % 4))) & 255;
            if (!f[2] && v >= 128) v = v + 32'hFFFFFF00;
        end else if (f[1:0] == 2'b01) begin
            v = (w >> (16 * ((a % 4) / 2))) & 65535;
            if (!f[2] && v >= 32768) v = v + 32'hFFFF0000;
        end else v = w;
        return v;
    endfunction

    task automatic run_op(input logic [1:0] cmd, input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] f, input int g, input int r, input logic [31:0] rd);
        bit err, tmo, done, granted;
        int exp_req, exp_wait, exp_stall, stalls, reqc, waitc;
        logic [31:0] exp_data, exp_wd;
        logic [3:0] exp_st;
        err = f[1:0] == 3 || (f[1:0] == 1 && a % 2 != 0) || (f[1:0] == 2 && a % 4 != 0);
        tmo = !err && (g >= TMO || (cmd == LD && r >= TMO));
        exp_req = err ? 0 : (g < TMO ? g + 1 : TMO);
        exp_wait = (err || cmd == ST || g >= TMO) ? 0 : (r < TMO ? r + 1 : TMO);
        exp_stall = 1 + exp_req + exp_wait;
        exp_data = cmd == LD ? ((err || tmo) ? ERR : ext(rd, a, f)) : last;
        exp_wd = f[1:0] == 0 ? (d & 255) * 32'h01010101 : f[1:0] == 1 ? (d & 65535) * 32'h00010001 : d;
        exp_st = cmd != ST ? 4'd0 : f[1:0] == 0 ? 4'(1 << (a % 4)) : f[1:0] == 1 ? 4'(3 << (a % 4)) : 4'd15;
        proc2Dmem_command = cmd;
        proc2Dmem_addr = a;
        proc2mem_data = d;
        mem_funct3 = f;
        stalls = 0; reqc = 0; waitc = 0; granted = 0; done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            #1;
            if (!dmem_stall) begin
                check("stall_cycles", 32'(stalls), 32'(exp_stall));
                check("req_cycles", 32'(reqc), 32'(exp_req));
                check("done_bus_err", 32'(bus_err), 32'(err || tmo));
                check("done_data", mem2proc_data, exp_data);
                check("done_req_low", 32'(mem_req), 32'd0);
                done = 1;
            end else begin
                check("stall_err_low", 32'(bus_err), 32'd0);
                check("stall_data_hold", mem2proc_data, last);
                if (mem_req) begin
                    check("req_addr", mem_addr, a & 32'hFFFFFFFC);
                    check("req_we", 32'(mem_we), 32'(cmd == ST));
                    check("req_wstrb", 32'(mem_wstrb), 32'(exp_st));
                    if (cmd == ST) check("req_wdata", mem_wdata, exp_wd);
                    mem_gnt = reqc == g;
                    mem_rvalid = 1'($urandom % 2);
                    mem_rdata = $urandom;
                    if (reqc == g) granted = 1;
                    reqc++;
                end else if (granted) begin
                    mem_gnt = 1'($urandom % 2);
                    mem_rvalid = waitc == r;
                    mem_rdata = waitc == r ? rd : $urandom;
                    waitc++;
                end else begin
                    mem_gnt = 1'($urandom % 2);
                    mem_rvalid = 1'($urandom % 2);
                    mem_rdata = $urandom;
                end
                stalls++;
                @(negedge clk);
            end
        end
        if (!done) check("hang", 32'(stalls), 32'(exp_stall));
        last = exp_data;
        mem_gnt = 1'($urandom % 2);
        mem_rvalid = 1'($urandom % 2);
        mem_rdata = $urandom;
        @(negedge clk);
    endtask

    task automatic idle_cycles(input int n);
        proc2Dmem_command = 2'd0;
        for (int i = 0; i < n; i++) begin
            mem_gnt = 1'($urandom % 2);
            mem_rvalid = 1'($urandom % 2);
            mem_rdata = $urandom;
            #1;
            check("idle_stall", 32'(dmem_stall), 32'd0);
            check("idle_req", 32'(mem_req), 32'd0);
            check("idle_err", 32'(bus_err), 32'd0);
            check("idle_data", mem2proc_data, last);
            @(negedge clk);
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [2:0] f;
        int g, r;
        #1;
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_wstrb", 32'(mem_wstrb), 32'd0);
        check("rst_data", mem2proc_data, 32'd0);
        check("rst_err", 32'(bus_err), 32'd0);
        check("rst_stall", 32'(dmem_stall), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(2);
        run_op(LD, 32'h100, 32'h0, 3'b010, 0, 0, 32'hCAFEF00D);
        run_op(ST, 32'h103, 32'hA5, 3'b000, 0, 0, 32'h0);
        run_op(LD, 32'h102, 32'h0, 3'b000, 0, 0, 32'h0080FF00);
        run_op(LD, 32'h102, 32'h0, 3'b100, 0, 0, 32'h0080FF00);
        run_op(LD, 32'h101, 32'h0, 3'b001, 0, 0, 32'h0);
        run_op(LD, 32'h100, 32'h0, 3'b010, 100, 0, 32'h0);
        run_op(ST, 32'h204, 32'h12345678, 3'b010, TMO - 1, 0, 32'h0);
        run_op(ST, 32'h206, 32'h0000BEEF, 3'b001, TMO, 0, 32'h0);
        run_op(LD, 32'h306, 32'h0, 3'b001, 2, TMO - 1, 32'h8001_7FFF);
        run_op(LD, 32'h304, 32'h0, 3'b101, 1, TMO, 32'h1234_5678);
        run_op(ST, 32'h402, 32'h0, 3'b011, 0, 0, 32'h0);
        idle_cycles(1);
        for (int k = 0; k < 200; k++) begin
            f = 3'($urandom);
            a = $urandom;
            if ($urandom % 4 != 0) a[1:0] = f[1:0] == 0 ? a[1:0] : f[1:0] == 1 ? {a[1], 1'b0} : 2'b00;
            g = $urandom % 10 == 0 ? TMO + int'($urandom % 3) : $urandom % 10 == 1 ? TMO - 1 : int'($urandom % 4);
            r = $urandom % 10 == 0 ? TMO + int'($urandom % 3) : $urandom % 10 == 1 ? TMO - 1 : int'($urandom % 4);
            run_op($urandom % 2 == 0 ? LD : ST, a, $urandom, f, g, r, $urandom);
            if ($urandom % 5 == 0) idle_cycles(1 + int'($urandom % 2));
        end
        run_op(LD, 32'h500, 32'h0, 3'b010, 0, 0, 32'h5A5A_1234);
        proc2Dmem_command = LD;
        proc2Dmem_addr = 32'h200;
        mem_funct3 = 3'b010;
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        @(negedge clk);
        mem_gnt = 1'b1;
        #1;
        check("pre_rst_req", 32'(mem_req), 32'd1);
        @(negedge clk);
        mem_gnt = 1'b0;
        #1;
        check("pre_rst_addr", mem_addr, 32'h200);
        check("pre_rst_stall", 32'(dmem_stall), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_req", 32'(mem_req), 32'd0);
        check("mid_rst_addr", mem_addr, 32'd0);
        check("mid_rst_data", mem2proc_data, 32'd0);
        check("mid_rst_err", 32'(bus_err), 32'd0);
        check("mid_rst_wstrb", 32'(mem_wstrb), 32'd0);
        last = 32'd0;
        @(negedge clk);
        proc2Dmem_command = 2'd0;
        rst_n = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata = 32'h1234_5678;
        @(negedge clk);
        #1;
        check("post_rst_data", mem2proc_data, 32'd0);
        check("post_rst_req", 32'(mem_req), 32'd0);
        check("post_rst_stall", 32'(dmem_stall), 32'd0);
        @(negedge clk);
        mem_rvalid = 1'b0;
        run_op(LD, 32'h600, 32'h0, 3'b000, 0, 1, 32'h0000_00F1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
